bus_rr_arbiter: RTL
===================

BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023, cycles of ISSUE without i_bus_ready before abort; 0 disables timeout.
REQ-002 SHALL have port i_clock  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port i_reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have, per requester X in {pa,pb,pc}: i_X_rw in 1 (1=write); i_X_request in 1; o_X_ready out 1; i_X_address in 32; o_X_rdata out 32; i_X_wdata in 32.
REQ-005 SHALL have shared-bus ports: o_bus_rw out 1; o_bus_request out 1; i_bus_ready in 1; o_bus_address out 32; i_bus_rdata in 32; o_bus_wdata out 32.
REQ-006 SHALL have o_grant out 2 (0=pa, 1=pb, 2=pc, 3=none), o_timeout out 1 (one-cycle pulse), o_fault out 1 (sticky).

Function
REQ-007 SHALL implement FSM IDLE -> ISSUE -> ACK -> RELEASE -> IDLE; all outputs registered.
REQ-008 Requester protocol: request held high with stable rw/address/wdata until its ready pulse; request dropped by the cycle after ready.
REQ-009 IDLE: if any request high at edge N, grant one port by round-robin, latch its rw/address/wdata onto o_bus_*, assert o_bus_request at N+1, go ISSUE.
REQ-010 Round-robin: priority order starts at port after last granted (pa->pb->pc->pa); after reset order is pa, pb, pc.
REQ-011 Non-granted requests SHALL be held pending, never dropped or reordered beyond REQ-010.
REQ-012 ISSUE: o_bus_request and o_bus_* stay constant; i_bus_ready at edge M -> at M+1 o_bus_request=0, o_X_rdata=i_bus_rdata (reads; writes leave rdata unchanged), o_X_ready=1, state ACK.
REQ-013 ACK lasts exactly one cycle; o_X_ready high only in ACK and only for granted port.
REQ-014 RELEASE: stay until granted request low, then IDLE; minimum one cycle; arbitration not performed in ACK or RELEASE.
REQ-015 Timeout counter: cleared on entry to ISSUE, increments per ISSUE cycle without ready; at count==TIMEOUT (TIMEOUT>0) -> o_bus_request=0, o_X_rdata=0, o_X_ready=1, o_timeout=1 one cycle, o_fault=1, state ACK.
REQ-016 i_bus_ready and timeout in same cycle: ready wins, no timeout/fault.
REQ-017 i_bus_ready outside ISSUE SHALL be ignored.
REQ-018 o_grant = granted port in ISSUE/ACK/RELEASE, 3 in IDLE.
REQ-019 Non-granted o_X_rdata SHALL hold previous value.
REQ-020 Throughput: back-to-back transactions from different ports separated by >=3 idle bus cycles (ACK, RELEASE, IDLE).

Reset
REQ-021 On i_reset high at an edge: state IDLE, o_bus_request=0, o_bus_rw=0, o_bus_address=0, o_bus_wdata=0, all o_X_ready=0, all o_X_rdata=0, o_grant=3, o_timeout=0, o_fault=0, counter=0, priority pointer to pa.
REQ-022 Reset mid-ISSUE SHALL drop o_bus_request at the next edge with no ready pulse to any requester.
REQ-023 o_fault clears only via reset.

Verification
REQ-024 Single read: pa request addr 0x100 at N, bus ready at N+3 with rdata 0x12345678 -> o_bus_request high N+1..N+3, o_pa_ready=1 at N+4 only, o_pa_rdata=0x12345678.
REQ-025 Write: pb rw=1 addr 0x200 wdata 0xCAFEF00D -> o_bus_rw=1, o_bus_address=0x200, o_bus_wdata=0xCAFEF00D stable through ISSUE; o_pb_rdata unchanged after ack.
REQ-026 Fairness: pa, pb, pc held high continuously, bus ready 1 cycle after each request -> grants pa, pb, pc, pa, pb, pc; no port starved.
REQ-027 Timeout: TIMEOUT=4, pc read, bus never ready -> o_timeout and o_pc_ready pulse on 5th cycle after ISSUE entry, o_pc_rdata=0, o_fault stays 1 until reset.
REQ-028 Ready/timeout collision: TIMEOUT=4, ready on the timeout cycle -> normal completion, o_timeout=0, o_fault=0.
REQ-029 Reset in ISSUE: assert i_reset one cycle during pa transaction -> o_bus_request=0 next cycle, no o_pa_ready, all outputs at REQ-021 values; next request granted normally.

Source files
------------

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing a single bus between three requesters (pa, pb, pc).
// Each transaction runs Idle -> Issue -> Ack -> Release -> Idle, and every output is registered.
//
// Ports:
//   i_clock, i_reset         sole clock and synchronous active-high reset
//   i_X_* / o_X_*            requester side for X in {pa, pb, pc}: request, rw (1=write),
//                            address, wdata in; ready pulse and rdata out
//   o_bus_* / i_bus_*        shared bus: request, rw, address, wdata out; ready, rdata in
//   o_grant                  granted port (0=pa, 1=pb, 2=pc), or 3 while idle
//   o_timeout                one-cycle pulse when a transaction is aborted
//   o_fault                  sticky abort flag, cleared only by reset
module bus_rr_arbiter #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_pa_rw,
  input  logic        i_pa_request,
  output logic        o_pa_ready,
  input  logic [31:0] i_pa_address,
  output logic [31:0] o_pa_rdata,
  input  logic [31:0] i_pa_wdata,
  input  logic        i_pb_rw,
  input  logic        i_pb_request,
  output logic        o_pb_ready,
  input  logic [31:0] i_pb_address,
  output logic [31:0] o_pb_rdata,
  input  logic [31:0] i_pb_wdata,
  input  logic        i_pc_rw,
  input  logic        i_pc_request,
  output logic        o_pc_ready,
  input  logic [31:0] i_pc_address,
  output logic [31:0] o_pc_rdata,
  input  logic [31:0] i_pc_wdata,
  output logic        o_bus_rw,
  output logic        o_bus_request,
  input  logic        i_bus_ready,
  output logic [31:0] o_bus_address,
  input  logic [31:0] i_bus_rdata,
  output logic [31:0] o_bus_wdata,
  output logic [1:0]  o_grant,
  output logic        o_timeout,
  output logic        o_fault
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StIssue, StAck, StRelease} state_e;

  state_e             state_q, state_d;
  logic [1:0]         grant_q, grant_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               bus_req_q, bus_req_d;
  logic               bus_rw_q, bus_rw_d;
  logic [31:0]        bus_addr_q, bus_addr_d;
  logic [31:0]        bus_wdata_q, bus_wdata_d;
  logic [2:0]         ready_q, ready_d;
  logic [2:0][31:0]   rdata_q, rdata_d;
  logic               timeout_q, timeout_d;
  logic               fault_q, fault_d;

  logic [2:0]         req_vec;
  logic [2:0]         rw_vec;
  logic [2:0][31:0]   addr_vec;
  logic [2:0][31:0]   wdata_vec;
  logic [1:0]         pick;

  assign req_vec   = {i_pc_request, i_pb_request, i_pa_request};
  assign rw_vec    = {i_pc_rw, i_pb_rw, i_pa_rw};
  assign addr_vec  = {i_pc_address, i_pb_address, i_pa_address};
  assign wdata_vec = {i_pc_wdata, i_pb_wdata, i_pa_wdata};

  // First requesting port at or after the pointer, wrapping pc -> pa.
  always_comb begin
    logic [2:0] idx;
    logic       found;
    pick  = 2'd3;
    found = 1'b0;
    idx   = 3'd0;
    for (int unsigned i = 0; i < 3; i++) begin
      idx = {1'b0, ptr_q} + 3'(i);
      if (idx >= 3'd3) idx = idx - 3'd3;
      if (!found && req_vec[idx[1:0]]) begin
        pick  = idx[1:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_rw_d    = bus_rw_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    ready_d     = '0;
    rdata_d     = rdata_q;
    timeout_d   = 1'b0;
    fault_d     = fault_q;

    unique case (state_q)
      StIdle: begin
        if (|req_vec) begin
          grant_d     = pick;
          ptr_d       = (pick == 2'd2) ? 2'd0 : pick + 2'd1;
          bus_req_d   = 1'b1;
          bus_rw_d    = rw_vec[pick];
          bus_addr_d  = addr_vec[pick];
          bus_wdata_d = wdata_vec[pick];
          cnt_d       = '0;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        // Ready takes precedence over a timeout expiring in the same cycle.
        if (i_bus_ready) begin
          bus_req_d        = 1'b0;
          ready_d[grant_q] = 1'b1;
          if (!bus_rw_q) rdata_d[grant_q] = i_bus_rdata;
          state_d          = StAck;
        end else if (TIMEOUT != 0 && cnt_q == TimeoutVal) begin
          bus_req_d        = 1'b0;
          ready_d[grant_q] = 1'b1;
          rdata_d[grant_q] = '0;
          timeout_d        = 1'b1;
          fault_d          = 1'b1;
          state_d          = StAck;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StAck: begin
        state_d = StRelease;
      end
      StRelease: begin
        if (!req_vec[grant_q]) begin
          grant_d = 2'd3;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= StIdle;
      grant_q     <= 2'd3;
      ptr_q       <= 2'd0;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_rw_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      ready_q     <= '0;
      rdata_q     <= '0;
      timeout_q   <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_rw_q    <= bus_rw_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      timeout_q   <= timeout_d;
      fault_q     <= fault_d;
    end
  end

  assign o_pa_ready    = ready_q[0];
  assign o_pb_ready    = ready_q[1];
  assign o_pc_ready    = ready_q[2];
  assign o_pa_rdata    = rdata_q[0];
  assign o_pb_rdata    = rdata_q[1];
  assign o_pc_rdata    = rdata_q[2];
  assign o_bus_request = bus_req_q;
  assign o_bus_rw      = bus_rw_q;
  assign o_bus_address = bus_addr_q;
  assign o_bus_wdata   = bus_wdata_q;
  assign o_grant       = grant_q;
  assign o_timeout     = timeout_q;
  assign o_fault       = fault_q;

endmodule
